// File: rtl/axi4l_pkg.sv
// Shared AXI4-Lite definitions for the register bank: response codes, FSM
// state encodings and the byte-lane merge helper.
package axi4l_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wstate_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rstate_t;

    // Sized for the widest legal data bus; callers zero-extend and truncate.
    function automatic logic [63:0] strb_merge(input logic [63:0] old_val,
                                               input logic [63:0] new_val,
                                               input logic [7:0]  strb);
        logic [63:0] res;
        res = old_val;
        for (int b = 0; b < 8; b++) begin
            if (strb[b]) begin
                res[b*8 +: 8] = new_val[b*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axi4l_reg_bank.sv
// AXI4-Lite slave exposing NUM_REGS read-write or read-only registers, with
// independent write and read FSMs and per-register access strobes.
module axi4l_reg_bank
    import axi4l_pkg::*;
#(
    parameter int                  ADDR_WIDTH = 32,
    parameter int                  DATA_WIDTH = 32,
    parameter int                  NUM_REGS   = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
    input  logic                           clk,
    input  logic                           rst,

    input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
    input  logic                           s_axi_awvalid,
    output logic                           s_axi_awready,

    input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
    input  logic                           s_axi_wvalid,
    output logic                           s_axi_wready,

    output logic [1:0]                     s_axi_bresp,
    output logic                           s_axi_bvalid,
    input  logic                           s_axi_bready,

    input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
    input  logic                           s_axi_arvalid,
    output logic                           s_axi_arready,

    output logic [DATA_WIDTH-1:0]          s_axi_rdata,
    output logic [1:0]                     s_axi_rresp,
    output logic                           s_axi_rvalid,
    input  logic                           s_axi_rready,

    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_in,
    output logic [NUM_REGS-1:0]            wr_pulse,
    output logic [NUM_REGS-1:0]            rd_pulse
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int IDX_W  = ADDR_WIDTH - LSB;
    localparam int SEL_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    wstate_t                 w_state_q, w_state_d;
    logic                    aw_lat_q, aw_lat_d;
    logic [IDX_W-1:0]        aw_idx_q, aw_idx_d;
    logic                    w_lat_q, w_lat_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]       wstrb_q, wstrb_d;
    logic [1:0]              bresp_q, bresp_d;
    logic [NUM_REGS-1:0]     wr_pulse_q, wr_pulse_d;
    logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];

    rstate_t                 r_state_q, r_state_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              rresp_q, rresp_d;
    logic [NUM_REGS-1:0]     rd_pulse_q, rd_pulse_d;

    logic [DATA_WIDTH-1:0]   ro_arr [NUM_REGS];
    logic                    aw_hs, w_hs, ar_hs;
    logic [IDX_W-1:0]        cur_idx, ar_idx;
    logic [DATA_WIDTH-1:0]   cur_data;
    logic [STRB_W-1:0]       cur_strb;
    logic                    unused_addr_lsbs;

    function automatic logic in_range(input logic [IDX_W-1:0] idx);
        return 64'(idx) < 64'(NUM_REGS);
    endfunction

    function automatic logic [SEL_W-1:0] sel_of(input logic [IDX_W-1:0] idx);
        return idx[SEL_W-1:0];
    endfunction

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
        assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
        assign ro_arr[i] = ro_in[i*DATA_WIDTH +: DATA_WIDTH];
    end

    assign unused_addr_lsbs = ^{s_axi_awaddr[LSB-1:0], s_axi_araddr[LSB-1:0]};

    // Handshake and response outputs are forced low for as long as rst is held.
    assign s_axi_awready = !rst && (w_state_q == W_IDLE) && !aw_lat_q;
    assign s_axi_wready  = !rst && (w_state_q == W_IDLE) && !w_lat_q;
    assign s_axi_bvalid  = !rst && (w_state_q == W_RESP);
    assign s_axi_bresp   = rst ? 2'b00 : bresp_q;
    assign s_axi_arready = !rst && (r_state_q == R_IDLE);
    assign s_axi_rvalid  = !rst && (r_state_q == R_DATA);
    assign s_axi_rresp   = rst ? 2'b00 : rresp_q;
    assign s_axi_rdata   = rst ? '0 : rdata_q;
    assign wr_pulse      = rst ? '0 : wr_pulse_q;
    assign rd_pulse      = rst ? '0 : rd_pulse_q;

    assign aw_hs = s_axi_awvalid && s_axi_awready;
    assign w_hs  = s_axi_wvalid && s_axi_wready;
    assign ar_hs = s_axi_arvalid && s_axi_arready;

    // A latched beat takes priority over the live bus for the commit.
    assign cur_idx  = aw_lat_q ? aw_idx_q : s_axi_awaddr[ADDR_WIDTH-1:LSB];
    assign cur_data = w_lat_q ? wdata_q : s_axi_wdata;
    assign cur_strb = w_lat_q ? wstrb_q : s_axi_wstrb;
    assign ar_idx   = s_axi_araddr[ADDR_WIDTH-1:LSB];

    always_comb begin
        w_state_d  = w_state_q;
        aw_lat_d   = aw_lat_q;
        aw_idx_d   = aw_idx_q;
        w_lat_d    = w_lat_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bresp_d    = bresp_q;
        wr_pulse_d = '0;
        regs_d     = regs_q;

        case (w_state_q)
            W_IDLE: begin
                if ((aw_lat_q || aw_hs) && (w_lat_q || w_hs)) begin
                    if (in_range(cur_idx) && !RO_MASK[sel_of(cur_idx)]) begin
                        regs_d[sel_of(cur_idx)] = DATA_WIDTH'(strb_merge(
                            64'(regs_q[sel_of(cur_idx)]), 64'(cur_data), 8'(cur_strb)));
                        wr_pulse_d[sel_of(cur_idx)] = 1'b1;
                        bresp_d = RESP_OKAY;
                    end else begin
                        bresp_d = RESP_SLVERR;
                    end
                    aw_lat_d  = 1'b0;
                    w_lat_d   = 1'b0;
                    w_state_d = W_RESP;
                end else begin
                    if (aw_hs) begin
                        aw_lat_d = 1'b1;
                        aw_idx_d = s_axi_awaddr[ADDR_WIDTH-1:LSB];
                    end
                    if (w_hs) begin
                        w_lat_d = 1'b1;
                        wdata_d = s_axi_wdata;
                        wstrb_d = s_axi_wstrb;
                    end
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Reads sample regs_q before this edge's commit, so a colliding write is not seen.
    always_comb begin
        r_state_d  = r_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        rd_pulse_d = '0;

        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    if (in_range(ar_idx)) begin
                        rdata_d = RO_MASK[sel_of(ar_idx)] ? ro_arr[sel_of(ar_idx)]
                                                          : regs_q[sel_of(ar_idx)];
                        rresp_d = RESP_OKAY;
                        rd_pulse_d[sel_of(ar_idx)] = 1'b1;
                    end else begin
                        rdata_d = '0;
                        rresp_d = RESP_SLVERR;
                    end
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (s_axi_rready) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q  <= W_IDLE;
            aw_lat_q   <= 1'b0;
            aw_idx_q   <= '0;
            w_lat_q    <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= 2'b00;
            wr_pulse_q <= '0;
            r_state_q  <= R_IDLE;
            rdata_q    <= '0;
            rresp_q    <= 2'b00;
            rd_pulse_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            w_state_q  <= w_state_d;
            aw_lat_q   <= aw_lat_d;
            aw_idx_q   <= aw_idx_d;
            w_lat_q    <= w_lat_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bresp_q    <= bresp_d;
            wr_pulse_q <= wr_pulse_d;
            r_state_q  <= r_state_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            rd_pulse_q <= rd_pulse_d;
            regs_q     <= regs_d;
        end
    end

endmodule

// File: tb/tb_axi4l_reg_bank.sv
// Directed bench for axi4l_reg_bank: a table of write/read-back vectors plus
// hand-written sequences for split handshakes, backpressure and reset.
module tb_axi4l_reg_bank;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 16;
    localparam logic [NR-1:0] RO = 16'h8000;

    logic             clk = 1'b0;
    logic             rst;
    logic [AW-1:0]    awaddr;
    logic             awvalid, awready;
    logic [DW-1:0]    wdata;
    logic [DW/8-1:0]  wstrb;
    logic             wvalid, wready;
    logic [1:0]       bresp;
    logic             bvalid, bready;
    logic [AW-1:0]    araddr;
    logic             arvalid, arready;
    logic [DW-1:0]    rdata;
    logic [1:0]       rresp;
    logic             rvalid, rready;
    logic [NR*DW-1:0] reg_out;
    logic [NR*DW-1:0] ro_in;
    logic [NR-1:0]    wr_pulse, rd_pulse;

    axi4l_reg_bank #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .RO_MASK(RO)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .reg_out(reg_out), .ro_in(ro_in), .wr_pulse(wr_pulse), .rd_pulse(rd_pulse)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [1:0]  bresp;
        logic [15:0] wp;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic [15:0] rp;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rout(input int i);
        return reg_out[i*DW +: DW];
    endfunction

    task automatic do_write(input string nm, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [1:0] exp_resp,
                            input logic [15:0] exp_wp);
        awaddr = a; awvalid = 1'b1;
        wdata = d; wstrb = s; wvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        chk({nm, ".bvalid"}, 64'(bvalid), 64'(1));
        chk({nm, ".bresp"}, 64'(bresp), 64'(exp_resp));
        chk({nm, ".wr_pulse"}, 64'(wr_pulse), 64'(exp_wp));
        bready = 1'b1;
        step();
        bready = 1'b0;
    endtask

    task automatic do_read(input string nm, input logic [31:0] a, input logic [31:0] exp_d,
                           input logic [1:0] exp_resp, input logic [15:0] exp_rp);
        araddr = a; arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        chk({nm, ".rvalid"}, 64'(rvalid), 64'(1));
        chk({nm, ".rdata"}, 64'(rdata), 64'(exp_d));
        chk({nm, ".rresp"}, 64'(rresp), 64'(exp_resp));
        chk({nm, ".rd_pulse"}, 64'(rd_pulse), 64'(exp_rp));
        rready = 1'b1;
        step();
        rready = 1'b0;
    endtask

    initial begin
        tbl[0] = '{32'h00, 32'h0000_0003, 4'hF, 2'b00, 16'h0001, 32'h0000_0003, 2'b00, 16'h0001};
        tbl[1] = '{32'h04, 32'h1122_3344, 4'hF, 2'b00, 16'h0002, 32'h1122_3344, 2'b00, 16'h0002};
        tbl[2] = '{32'h04, 32'hAABB_CCDD, 4'h5, 2'b00, 16'h0002, 32'h11BB_33DD, 2'b00, 16'h0002};
        tbl[3] = '{32'h40, 32'h1234_5678, 4'hF, 2'b10, 16'h0000, 32'h0000_0000, 2'b10, 16'h0000};
        tbl[4] = '{32'h3C, 32'hFFFF_FFFF, 4'hF, 2'b10, 16'h0000, 32'hCAFE_0015, 2'b00, 16'h8000};
        tbl[5] = '{32'h0B, 32'h0000_A5A5, 4'h3, 2'b00, 16'h0004, 32'h0000_A5A5, 2'b00, 16'h0004};
        tbl[6] = '{32'h0C, 32'hFFFF_FFFF, 4'h0, 2'b00, 16'h0008, 32'h0000_0000, 2'b00, 16'h0008};

        rst = 1'b1;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0;
        ro_in = '0;
        ro_in[15*DW +: DW] = 32'hCAFE_0015;

        // Reset state
        step(); step();
        chk("rst.awready", 64'(awready), 64'(0));
        chk("rst.wready", 64'(wready), 64'(0));
        chk("rst.arready", 64'(arready), 64'(0));
        chk("rst.bvalid", 64'(bvalid), 64'(0));
        chk("rst.rvalid", 64'(rvalid), 64'(0));
        chk("rst.reg_out_or", 64'(|reg_out), 64'(0));
        rst = 1'b0;
        #1;
        chk("post_rst.awready", 64'(awready), 64'(1));
        chk("post_rst.wready", 64'(wready), 64'(1));
        chk("post_rst.arready", 64'(arready), 64'(1));
        step();

        for (int i = 0; i < 7; i++) begin
            do_write($sformatf("vec%0d.wr", i), tbl[i].addr, tbl[i].wdata, tbl[i].strb,
                     tbl[i].bresp, tbl[i].wp);
            do_read($sformatf("vec%0d.rd", i), tbl[i].addr, tbl[i].rdata, tbl[i].rresp,
                    tbl[i].rp);
        end
        chk("ro_reg_untouched", 64'(rout(15)), 64'(0));
        chk("reg1_after_strobe", 64'(rout(1)), 64'(32'h11BB_33DD));
        chk("reg0_after_slverr", 64'(rout(0)), 64'(3));

        // Same-edge write and read of reg 0
        awaddr = 32'h0; wdata = 32'h5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 32'h0; arvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        chk("collide.rdata", 64'(rdata), 64'(3));
        chk("collide.bvalid", 64'(bvalid), 64'(1));
        chk("collide.reg0", 64'(rout(0)), 64'(5));
        bready = 1'b1; rready = 1'b1;
        step();
        bready = 1'b0; rready = 1'b0;
        do_read("collide.reread", 32'h0, 32'h5, 2'b00, 16'h0001);

        // AW first, W three cycles later, then bready backpressure
        awaddr = 32'h08; awvalid = 1'b1;
        step();
        awvalid = 1'b0;
        chk("split.awready_latched", 64'(awready), 64'(0));
        chk("split.wready_open", 64'(wready), 64'(1));
        step(); step();
        chk("split.no_early_bvalid", 64'(bvalid), 64'(0));
        wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1'b1;
        step();
        wvalid = 1'b0;
        chk("split.bvalid", 64'(bvalid), 64'(1));
        chk("split.bresp", 64'(bresp), 64'(0));
        chk("split.reg2", 64'(rout(2)), 64'(32'hDEAD_BEEF));
        chk("split.wr_pulse", 64'(wr_pulse), 64'(16'h0004));
        for (int c = 0; c < 5; c++) begin
            step();
            chk($sformatf("hold%0d.bvalid", c), 64'(bvalid), 64'(1));
            chk($sformatf("hold%0d.bresp", c), 64'(bresp), 64'(0));
            chk($sformatf("hold%0d.readies", c), 64'({awready, wready}), 64'(0));
            chk($sformatf("hold%0d.wr_pulse", c), 64'(wr_pulse), 64'(0));
        end
        bready = 1'b1;
        step();
        bready = 1'b0;
        chk("hold.release_bvalid", 64'(bvalid), 64'(0));
        chk("hold.release_awready", 64'(awready), 64'(1));

        // W before AW
        wdata = 32'h4444_4444; wstrb = 4'hF; wvalid = 1'b1;
        step();
        wvalid = 1'b0;
        chk("wfirst.wready_latched", 64'(wready), 64'(0));
        chk("wfirst.awready_open", 64'(awready), 64'(1));
        chk("wfirst.no_bvalid", 64'(bvalid), 64'(0));
        awaddr = 32'h10; awvalid = 1'b1;
        step();
        awvalid = 1'b0;
        chk("wfirst.bvalid", 64'(bvalid), 64'(1));
        chk("wfirst.reg4", 64'(rout(4)), 64'(32'h4444_4444));
        chk("wfirst.wr_pulse", 64'(wr_pulse), 64'(16'h0010));
        bready = 1'b1;
        step();
        bready = 1'b0;

        // Reset between AW and W abandons the write
        awaddr = 32'h04; awvalid = 1'b1;
        step();
        awvalid = 1'b0;
        chk("abandon.aw_latched", 64'(awready), 64'(0));
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        #1;
        chk("abandon.awready", 64'(awready), 64'(1));
        chk("abandon.wready", 64'(wready), 64'(1));
        chk("abandon.reg1", 64'(rout(1)), 64'(0));
        step();
        wdata = 32'h0000_0077; wstrb = 4'hF; wvalid = 1'b1;
        step();
        wvalid = 1'b0;
        chk("abandon.no_bvalid", 64'(bvalid), 64'(0));
        chk("abandon.no_wr_pulse", 64'(wr_pulse), 64'(0));
        chk("abandon.reg1_still", 64'(rout(1)), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
